// File: rtl/tdm_demux_4ch.sv
// ---------------------------------------------------------------------------
// tdm_demux_4ch
//
// Receive-side partner of the 4-input TDM multiplexer. A stream of valid
// beats arrives in slot order 0..3 (channels a, b, c, d), with frame_sync
// marking the slot-0 beat. The first three words of a frame are parked in
// shadow registers. When the slot-3 beat arrives, all four channel outputs
// are updated together and out_valid pulses for one cycle.
//
// The block hunts for frame_sync, then stays locked while the framing holds.
// A framing violation pulses sync_err:
//   - early sync: frame_sync arrives before slot 0. The beat restarts the
//     frame as slot 0 and the block stays locked.
//   - missing sync: slot 0 arrives without frame_sync. The beat is dropped
//     and the block goes back to hunting.
//
// Parameters
//   WIDTH       bit width of din and of each channel word
//
// Ports
//   clock       system clock, rising-edge active
//   reset       asynchronous, active-high reset
//   din         multiplexed data word
//   in_valid    din carries a beat this cycle
//   frame_sync  qualified by in_valid; marks the beat as slot 0
//   a, b, c, d  registered channel words 0..3 of the last complete frame
//   out_valid   one-cycle pulse: a..d just took a new complete frame
//   slot        slot index expected for the next valid beat
//   locked      high while the block is frame-aligned
//   sync_err    one-cycle pulse on a framing violation
// ---------------------------------------------------------------------------
module tdm_demux_4ch #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             in_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [1:0] SLOT_FIRST = 2'd0;
  localparam logic [1:0] SLOT_LAST  = 2'd3;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;
  logic [WIDTH-1:0] sh2;

  // Beat classification. Exactly one of these is high on any beat, and all
  // of them are low when in_valid is low, so idle cycles hold every register.
  logic at_slot0;
  logic hunt_sync;
  logic hunt_drop;
  logic early_sync;
  logic missing_sync;
  logic normal_beat;
  logic frame_done;

  // A beat is "normal" when frame_sync agrees with the slot position: it must
  // be high exactly on slot 0. The two ways to disagree are the two error
  // cases. The slot-3 normal beat is the one that completes a frame.
  always_comb begin
    at_slot0     = (slot == SLOT_FIRST);
    hunt_sync    = in_valid && (state == ST_HUNT) &&  frame_sync;
    hunt_drop    = in_valid && (state == ST_HUNT) && !frame_sync;
    early_sync   = in_valid && (state == ST_LOCKED) &&  frame_sync && !at_slot0;
    missing_sync = in_valid && (state == ST_LOCKED) && !frame_sync &&  at_slot0;
    normal_beat  = in_valid && (state == ST_LOCKED) && (frame_sync == at_slot0);
    frame_done   = normal_beat && (slot == SLOT_LAST);
  end

  assign locked = (state == ST_LOCKED);

  // Alignment state. Any sync seen while hunting acquires lock. A missing
  // sync drops lock. An early sync re-aligns the frame without losing lock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_HUNT;
    end else if (hunt_sync) begin
      state <= ST_LOCKED;
    end else if (missing_sync) begin
      state <= ST_HUNT;
    end
  end

  // Slot counter. Any beat accepted as slot 0 (an acquiring sync or an early
  // sync) moves the counter to 1. A normal beat advances it, and the 2-bit
  // wrap from 3 back to 0 ends the frame. Discarded beats leave it at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot <= SLOT_FIRST;
    end else if (hunt_sync || early_sync) begin
      slot <= 2'd1;
    end else if (normal_beat) begin
      slot <= slot + 2'd1;
    end else if (missing_sync || hunt_drop) begin
      slot <= SLOT_FIRST;
    end
  end

  // Shadow capture for slots 0..2. These registers are not cleared on a
  // framing error. Stale words can never reach a..d, because a frame only
  // completes after slots 0..2 have all been rewritten in order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh0 <= '0;
      sh1 <= '0;
      sh2 <= '0;
    end else if (hunt_sync || early_sync) begin
      sh0 <= din;
    end else if (normal_beat) begin
      case (slot)
        2'd0:    sh0 <= din;
        2'd1:    sh1 <= din;
        2'd2:    sh2 <= din;
        default: ;
      endcase
    end
  end

  // Channel outputs change only when a frame completes. Until then they hold
  // the last complete frame, including across errors and loss of lock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a <= '0;
      b <= '0;
      c <= '0;
      d <= '0;
    end else if (frame_done) begin
      a <= sh0;
      b <= sh1;
      c <= sh2;
      d <= din;
    end
  end

  // Registered status pulses. Each one is recomputed every cycle, so it is
  // high for exactly one cycle. A frame completion and a framing error come
  // from disjoint beat classes, so the two pulses can never coincide.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= frame_done;
      sync_err  <= early_sync || missing_sync;
    end
  end

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_4ch
//
// Bench for tdm_demux_4ch. A driver issues one beat (or one idle cycle) at
// every falling clock edge. It also advances a frame-level reference model
// built from a position counter and a word array. Each frame the model
// expects to complete is pushed into a queue. A monitor samples just after
// every rising edge and checks the DUT against the model: completed frames
// are popped from the queue when out_valid rises, and the held a..d, slot,
// locked and pulse outputs are compared every cycle. Directed scenarios run
// first, followed by a randomized stream.
// ---------------------------------------------------------------------------
module tb_tdm_demux_4ch;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             in_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] a, b, c, d;
  logic             out_valid;
  logic [1:0]       slot;
  logic             locked;
  logic             sync_err;

  tdm_demux_4ch #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .din        (din),
    .in_valid   (in_valid),
    .frame_sync (frame_sync),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .out_valid  (out_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  // 10 time-unit clock period.
  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;
  bit monitor_on   = 1'b0;

  // Reference model state.
  logic [31:0] frame_q[$];
  bit          m_locked;
  int          m_pos;
  logic [7:0]  part[4];
  logic [31:0] held;
  bit          exp_ov;
  bit          exp_err;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_locked = 1'b0;
    m_pos    = 0;
    held     = '0;
    exp_ov   = 1'b0;
    exp_err  = 1'b0;
    for (int i = 0; i < 4; i++) part[i] = '0;
    frame_q.delete();
  endtask

  // Drive one cycle of input, then predict what the DUT shows after the
  // coming rising edge. The model works on frame positions: a sync restarts
  // the frame, a word arriving at position 0 without sync loses lock, and
  // four aligned words make a frame.
  task automatic applyStimulus(input bit v, input bit fs, input logic [7:0] data);
    @(negedge clock);
    in_valid   = v;
    frame_sync = fs;
    din        = data;
    exp_ov     = 1'b0;
    exp_err    = 1'b0;
    if (v && !reset) begin
      if (!m_locked) begin
        if (fs) begin
          part[0]  = data;
          m_pos    = 1;
          m_locked = 1'b1;
        end
      end else if (fs && m_pos != 0) begin
        exp_err = 1'b1;
        part[0] = data;
        m_pos   = 1;
      end else if (!fs && m_pos == 0) begin
        exp_err  = 1'b1;
        m_locked = 1'b0;
      end else begin
        part[m_pos] = data;
        if (m_pos == 3) begin
          held = {part[0], part[1], part[2], part[3]};
          frame_q.push_back(held);
          exp_ov = 1'b1;
          m_pos  = 0;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  // Drive one frame: sync on the first beat, then the other three words.
  task automatic sendFrame(input logic [31:0] words);
    applyStimulus(1'b1, 1'b1, words[31:24]);
    applyStimulus(1'b1, 1'b0, words[23:16]);
    applyStimulus(1'b1, 1'b0, words[15:8]);
    applyStimulus(1'b1, 1'b0, words[7:0]);
  endtask

  // Used by directed checks: wait until just after the rising edge that
  // consumed the last driven cycle.
  task automatic waitEdge();
    @(posedge clock);
    #3;
  endtask

  // Monitor: compare the registered outputs against the model once per cycle.
  always @(posedge clock) begin
    #2;
    if (monitor_on && !reset) begin
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      checkOutput("sync_err", {31'd0, sync_err}, {31'd0, exp_err});
      checkOutput("slot", {30'd0, slot}, 32'(m_pos));
      checkOutput("locked", {31'd0, locked}, {31'd0, m_locked});
      checkOutput("abcd_hold", {a, b, c, d}, held);
      if (out_valid) begin
        if (frame_q.size() == 0) begin
          checkOutput("frame_unexpected", {a, b, c, d}, 32'hxxxx_xxxx);
        end else begin
          checkOutput("frame", {a, b, c, d}, frame_q.pop_front());
        end
      end
    end
  end

  // Watchdog: stop the run if the main sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit fs;
    bit v;

    reset      = 1'b1;
    in_valid   = 1'b0;
    frame_sync = 1'b0;
    din        = '0;
    modelReset();
    #12;
    checkOutput("reset_abcd", {a, b, c, d}, 32'h0);
    checkOutput("reset_flags", {28'd0, out_valid, sync_err, locked, 1'b0}, 32'h0);
    checkOutput("reset_slot", {30'd0, slot}, 32'h0);
    @(negedge clock);
    reset      = 1'b0;
    monitor_on = 1'b1;

    // Test 1: a plain frame.
    sendFrame({8'd11, 8'd22, 8'd33, 8'd44});
    waitEdge();
    checkOutput("t1_abcd", {a, b, c, d}, 32'h0B16212C);
    checkOutput("t1_ov", {31'd0, out_valid}, 32'd1);
    checkOutput("t1_locked", {31'd0, locked}, 32'd1);
    checkOutput("t1_slot", {30'd0, slot}, 32'd0);

    // Test 2: a gap of idle cycles inside the frame.
    applyStimulus(1'b1, 1'b1, 8'd11);
    applyStimulus(1'b1, 1'b0, 8'd22);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'hEE);
    waitEdge();
    checkOutput("t2_slot_gap", {30'd0, slot}, 32'd2);
    applyStimulus(1'b1, 1'b0, 8'd33);
    applyStimulus(1'b1, 1'b0, 8'd44);
    waitEdge();
    checkOutput("t2_abcd", {a, b, c, d}, 32'h0B16212C);
    checkOutput("t2_ov", {31'd0, out_valid}, 32'd1);

    // Test 3: an early sync restarts the frame.
    applyStimulus(1'b1, 1'b1, 8'd11);
    applyStimulus(1'b1, 1'b0, 8'd22);
    applyStimulus(1'b1, 1'b1, 8'd55);
    waitEdge();
    checkOutput("t3_err", {30'd0, sync_err, out_valid}, 32'd2);
    applyStimulus(1'b1, 1'b0, 8'd66);
    applyStimulus(1'b1, 1'b0, 8'd77);
    applyStimulus(1'b1, 1'b0, 8'd88);
    waitEdge();
    checkOutput("t3_abcd", {a, b, c, d}, 32'h37424D58);

    // Test 4: a missing sync loses lock, and beats are ignored until a sync.
    applyStimulus(1'b1, 1'b0, 8'd99);
    waitEdge();
    checkOutput("t4_err", {30'd0, sync_err, locked}, 32'd2);
    applyStimulus(1'b1, 1'b0, 8'd1);
    applyStimulus(1'b1, 1'b0, 8'd2);
    waitEdge();
    checkOutput("t4_hold", {a, b, c, d}, 32'h37424D58);
    checkOutput("t4_unlocked", {31'd0, locked}, 32'd0);

    // Test 6: back-to-back frames.
    sendFrame(32'h01020304);
    waitEdge();
    checkOutput("t6_first", {a, b, c, d}, 32'h01020304);
    applyStimulus(1'b1, 1'b1, 8'd5);
    waitEdge();
    checkOutput("t6_gap_ov", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'd6);
    applyStimulus(1'b1, 1'b0, 8'd7);
    applyStimulus(1'b1, 1'b0, 8'd8);
    waitEdge();
    checkOutput("t6_second", {a, b, c, d}, 32'h05060708);
    checkOutput("t6_ov", {31'd0, out_valid}, 32'd1);

    // Test 5: asynchronous reset mid-frame, taking effect between clock edges.
    applyStimulus(1'b1, 1'b1, 8'hA1);
    applyStimulus(1'b1, 1'b0, 8'hA2);
    waitEdge();
    checkOutput("t5_slot_before", {30'd0, slot}, 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("t5_abcd", {a, b, c, d}, 32'h0);
    checkOutput("t5_state", {29'd0, out_valid, locked, sync_err}, 32'h0);
    checkOutput("t5_slot", {30'd0, slot}, 32'h0);
    modelReset();
    applyStimulus(1'b0, 1'b0, 8'h00);
    #2;
    reset = 1'b0;
    sendFrame(32'hC1C2C3C4);
    waitEdge();
    checkOutput("t5_after", {a, b, c, d}, 32'hC1C2C3C4);

    // Randomized stream: mostly well-formed framing, with occasional flipped
    // syncs and idle cycles.
    for (int i = 0; i < 800; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      fs = m_locked ? (m_pos == 0) : ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) fs = !fs;
      applyStimulus(v, fs, 8'($urandom));
    end

    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    waitEdge();
    checkOutput("queue_empty", 32'(frame_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
